// File: rtl/serial_adder_if.sv
// Operand and result handshake bundle for the bit-serial adder.
// The slave side is the adder; the master side is the producer/consumer.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  modport master (
    output in_valid, a, b, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out
  );

  modport slave (
    input  in_valid, a, b, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice made of two half adders evaluates one bit per
// cycle, LSB first, so a WIDTH-bit add takes WIDTH cycles between the two handshakes.
module serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             c_q, c_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic s1, c1, s, c2;

  // Full-adder slice: two cascaded half adders, carries merged with an OR.
  always_comb begin
    s1 = a_sh_q[0] ^ b_sh_q[0];
    c1 = a_sh_q[0] & b_sh_q[0];
    s  = s1 ^ c_q;
    c2 = s1 & c_q;
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_d     = bus.carry_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Shift expression rather than a slice so WIDTH=1 stays legal.
        res_d  = (res_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        c_d    = c1 | c2;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = res_q;
  assign bus.carry_out = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized bench for serial_adder against a plain-arithmetic reference sum.
module tb_serial_adder;
  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
  endfunction

  // One transaction; optional result stall and junk in_valid pokes while busy.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       input int stall, input bit poke);
    logic [W:0] exp;
    int lat;
    exp = ref_add(x, y, ci);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a = x;
    bus.b = y;
    bus.carry_in = ci;
    bus.in_valid = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    bus.in_valid = poke;
    bus.a = ~x;
    bus.b = x ^ y ^ 16'h3C3C;
    bus.carry_in = ~ci;
    check("in_ready_run", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd16);
    check("sum", 32'(bus.sum), 32'(exp[W-1:0]));
    check("carry_out", 32'(bus.carry_out), 32'(exp[W]));
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_sum", 32'(bus.sum), 32'(exp[W-1:0]));
        check("hold_carry", 32'(bus.carry_out), 32'(exp[W]));
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int unsigned acc [5];
    logic [W:0] exp;
    logic [W-1:0] x, y;
    int guard;

    bus.in_valid = 1'b1;  // must be ignored while in reset
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    bus.carry_in = 1'b1;
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_carry", 32'(bus.carry_out), 32'd0);
    bus.in_valid = 1'b0;
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", 32'(bus.in_ready), 32'd1);

    do_op(16'h0000, 16'h0000, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
    do_op(16'hA5A5, 16'h5A5B, 1'b0, 5, 1'b1);

    // Abort mid-RUN with an asynchronous reset between clock edges.
    bus.a = 16'hFFFF;
    bus.b = 16'h0000;
    bus.carry_in = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_carry", 32'(bus.carry_out), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);

    // Back-to-back with out_ready tied high: accepts every W+2 cycles.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      exp = ref_add(x, y, 1'b0);
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      bus.a = x;
      bus.b = y;
      bus.carry_in = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      acc[k] = cyc;
      bus.in_valid = 1'b0;
      guard = 0;
      while (!bus.out_valid && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      check("b2b_sum", 32'(bus.sum), 32'(exp[W-1:0]));
      check("b2b_carry", 32'(bus.carry_out), 32'(exp[W]));
      if (k > 0) check("b2b_period", acc[k] - acc[k-1], 32'd18);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    repeat (20) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(3, 0)),
            1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, multi-cycle adder that sits downstream of the half_adder cell.
- Per cycle it evaluates one bit position with a full-adder slice built from two half_adder instances plus an OR for the carry.
- It is the area-minimal sequential alternative to the ripple Add16, used by the Hack datapath experiments.
- Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a, b, carry_in presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- carry_in  input  1  carry into bit 0
- out_valid  output  1  sum/carry_out hold a completed result
- out_ready  input  1  consumer takes the result
- sum  output  WIDTH  a + b + carry_in, modulo 2^WIDTH
- carry_out  output  1  carry out of bit WIDTH-1

Behaviour:
- Interface: one clock, clk; reset asynchronous active-low on rst_n.
- States: IDLE, RUN, DONE.
- Internal registers:
  - a_sh, b_sh (WIDTH each): operand shift registers.
  - res (WIDTH): result shift register.
  - c (1): running carry.
  - cnt: $clog2(WIDTH+1) bits.
- Reset (rst_n low, takes effect immediately, independent of clk):
  - state=IDLE; a_sh, b_sh, res, c, cnt = 0.
  - out_valid=0, sum=0, carry_out=0.
- in_ready = (state==IDLE). It is therefore 1 while in reset; in_valid is ignored while rst_n is low.
- IDLE:
  - On an edge with in_valid & in_ready: a_sh<=a, b_sh<=b, c<=carry_in, res<=0, cnt<=0, state<=RUN.
  - Otherwise hold all registers.
- RUN, every edge:
  - Slice inputs x=a_sh[0], y=b_sh[0], c.
  - Half-adder 1: s1=x^y, c1=x&y.
  - Half-adder 2: s=s1^c, c2=s1&c.
  - res<={s, res[WIDTH-1:1]}; a_sh, b_sh shift right by 1 with zero fill.
  - c<=c1|c2; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: state<=DONE.
- Latency:
  - Operands accepted on edge E0; out_valid rises after edge E0+WIDTH (16 cycles at default).
  - Throughput: one result per WIDTH+2 cycles when out_ready is held high.
- DONE:
  - out_valid=1; sum=res; carry_out=c.
  - Values stay stable until the handshake.
  - On an edge with out_ready=1: state<=IDLE, out_valid drops after that edge, in_ready=1 the following cycle.
  - No same-cycle accept/complete overlap.
- sum and carry_out are driven from res and c in all states. They are only meaningful while out_valid=1; the consumer must ignore them otherwise.
- in_valid asserted during RUN or DONE is not accepted (in_ready=0). a, b, carry_in may change freely after acceptance.
- out_ready asserted outside DONE has no effect.
- rst_n asserted mid-RUN or mid-DONE aborts the operation: returns to IDLE with all outputs zero; the partial result is discarded.
- WIDTH=1: RUN lasts exactly one edge; cnt comparison still holds.
- Overflow wraps modulo 2^WIDTH; the lost bit appears only on carry_out.

Test Plan:
- Reset, then a=0x0000, b=0x0000, carry_in=0, out_ready=1:
  - in_ready=1 before the handshake.
  - out_valid rises exactly 16 cycles after acceptance, with sum=0x0000, carry_out=0.
  - in_ready returns to 1 after the DONE edge.
- a=0xFFFF, b=0x0001, carry_in=0 → sum=0x0000, carry_out=1.
- a=0x1234, b=0x4321, carry_in=1 → sum=0x5556, carry_out=0.
- a=0x8000, b=0x8000 → sum=0x0000, carry_out=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE: out_valid, sum and carry_out stay constant.
  - Assert in_valid during RUN and DONE with different operands: those operands are not accepted and the result is unchanged.
  - Raise out_ready: IDLE on the next edge.
- Reset mid-operation: pull rst_n low asynchronously (between edges) 7 cycles into RUN.
  - out_valid=0, sum=0, carry_out=0 immediately.
  - After release, in_ready=1; a fresh 0x00FF+0x0001 returns sum=0x0100, carry_out=0 with full 16-cycle latency.
  - Back-to-back pairs with out_ready tied high complete every 18 cycles.
